// File: rtl/somador_serial_ctrl.sv
// Bit-serial adder controller: captures two WIDTH-bit operands on a start key press and
// adds them LSB first through one shared full-adder cell, latching {carry, sum} on LEDG.
module somador_serial_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic [2*WIDTH-1:0] SW,
  input  logic [1:0]         KEY,
  output logic [WIDTH:0]     LEDG,
  output logic [1:0]         LEDR
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Returns {carry_out, sum} for one full-adder step.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    logic s;
    logic co;
    s  = a ^ b ^ c;
    co = (a & b) | ((a ^ b) & c);
    return {co, s};
  endfunction

  state_t            state_r;
  logic [1:0]        key_sync1_r;
  logic [1:0]        key_sync2_r;
  logic [1:0]        key_prev_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [WIDTH-1:0]  sum_r;
  logic              carry_r;
  logic [CW-1:0]     cnt_r;
  logic [WIDTH:0]    ledg_r;
  logic              busy_r;
  logic              done_r;
  logic [1:0]        press_s;
  logic [1:0]        fa_s;
  logic              start_s;
  logic              clear_s;

  assign press_s = key_prev_r & ~key_sync2_r;
  assign start_s = press_s[0];
  assign clear_s = press_s[1];
  assign fa_s    = full_add(a_r[0], b_r[0], carry_r);

  // Key synchronisers and edge detector; released (1) is the idle level.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      key_sync1_r <= 2'b11;
      key_sync2_r <= 2'b11;
      key_prev_r  <= 2'b11;
    end else begin
      key_sync1_r <= KEY;
      key_sync2_r <= key_sync1_r;
      key_prev_r  <= key_sync2_r;
    end
  end

  // Sequencer: clear outranks start and aborts any operation in flight.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      ledg_r  <= {(WIDTH+1){1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (clear_s) begin
      state_r <= IDLE;
      ledg_r  <= {(WIDTH+1){1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            a_r     <= SW[WIDTH-1:0];
            b_r     <= SW[2*WIDTH-1:WIDTH];
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= LOAD;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          state_r <= ADD;
        end
        ADD: begin
          sum_r   <= {fa_s[0], sum_r[WIDTH-1:1]};
          carry_r <= fa_s[1];
          a_r     <= {1'b0, a_r[WIDTH-1:1]};
          b_r     <= {1'b0, b_r[WIDTH-1:1]};
          cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == CW'(WIDTH-1)) begin
            state_r <= DONE;
          end else begin
            state_r <= ADD;
          end
        end
        DONE: begin
          ledg_r  <= {carry_r, sum_r};
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign LEDG = ledg_r;
  assign LEDR = {done_r, busy_r};

endmodule

// File: tb/tb_somador_serial_ctrl.sv
// Self-checking bench for somador_serial_ctrl (WIDTH=5): table-driven operations with a
// result scoreboard, plus hand-written sequences for ignored start, abort, clear and reset.
module tb_somador_serial_ctrl;

  localparam int WIDTH = 5;

  logic               clk;
  logic               rst;
  logic [2*WIDTH-1:0] sw;
  logic [1:0]         key;
  logic [WIDTH:0]     ledg;
  logic [1:0]         ledr;

  int checks;
  int errors;
  logic [WIDTH:0] exp_q[$];

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
  } vec_t;

  vec_t vecs[7];

  somador_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .CLOCK_50(clk),
    .RESET(rst),
    .SW(sw),
    .KEY(key),
    .LEDG(ledg),
    .LEDR(ledr)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name);
    logic [WIDTH:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %0d", name, ledg);
    end else begin
      e = exp_q.pop_front();
      chk(name, {26'd0, ledg}, {26'd0, e});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // e counts rising edges from the first one that samples KEY[0]=0; sampling is at negedge.
  task automatic op(input vec_t v);
    sw = {v.b, v.a};
    exp_q.push_back(v.sum);
    key[0] = 1'b0;
    for (int e = 0; e <= 9; e++) begin
      @(negedge clk);
      if (e == 2) key[0] = 1'b1;
      if (e < 9) begin
        chk("busy", {31'd0, ledr[0]}, (e >= 2) ? 32'd1 : 32'd0);
        if (e >= 2) chk("done_cleared", {31'd0, ledr[1]}, 32'd0);
      end else begin
        sb_check("sum");
        chk("ledr_final", {30'd0, ledr}, 32'd2);
      end
    end
    idle(2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{a: 5'd31, b: 5'd31, sum: 6'd62};
    vecs[1] = '{a: 5'd21, b: 5'd10, sum: 6'd31};
    vecs[2] = '{a: 5'd0,  b: 5'd0,  sum: 6'd0};
    vecs[3] = '{a: 5'd1,  b: 5'd31, sum: 6'd32};
    vecs[4] = '{a: 5'd17, b: 5'd14, sum: 6'd31};
    vecs[5] = '{a: 5'd8,  b: 5'd23, sum: 6'd31};
    vecs[6] = '{a: 5'd19, b: 5'd6,  sum: 6'd25};

    rst = 1'b1;
    key = 2'b11;
    sw  = 10'd0;
    idle(3);
    chk("reset_ledg", {26'd0, ledg}, 32'd0);
    chk("reset_ledr", {30'd0, ledr}, 32'd0);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 7; i++) op(vecs[i]);

    // Result must hold while idle.
    idle(5);
    chk("hold_ledg", {26'd0, ledg}, 32'd25);
    chk("hold_ledr", {30'd0, ledr}, 32'd2);

    // Second start during ADD plus SW change: ignored, not queued.
    sw = {5'd4, 5'd3};
    exp_q.push_back(6'd7);
    key[0] = 1'b0;
    for (int e = 0; e <= 14; e++) begin
      @(negedge clk);
      if (e == 1) key[0] = 1'b1;
      if (e == 3) begin
        key[0] = 1'b0;
        sw = {5'd31, 5'd31};
      end
      if (e == 5) key[0] = 1'b1;
      if (e == 9) sb_check("ignored_start_sum");
      if (e >= 10) chk("ignored_start_idle", {31'd0, ledr[0]}, 32'd0);
    end

    // Clear during ADD aborts; nothing latched afterwards.
    sw = {5'd1, 5'd31};
    key[0] = 1'b0;
    for (int e = 0; e <= 12; e++) begin
      @(negedge clk);
      if (e == 2) key[0] = 1'b1;
      if (e == 4) key[1] = 1'b0;
      if (e == 6) begin
        chk("abort_pre_busy", {31'd0, ledr[0]}, 32'd1);
        chk("abort_pre_ledg", {26'd0, ledg}, 32'd7);
      end
      if (e == 7) key[1] = 1'b1;
      if (e >= 7) begin
        chk("abort_ledg", {26'd0, ledg}, 32'd0);
        chk("abort_ledr", {30'd0, ledr}, 32'd0);
      end
    end
    idle(3);

    // Clear in IDLE wipes result and done.
    op(vecs[3]);
    key[1] = 1'b0;
    for (int e = 0; e <= 4; e++) begin
      @(negedge clk);
      if (e == 1) chk("clr_idle_pre", {26'd0, ledg}, 32'd32);
      if (e == 2) key[1] = 1'b1;
      if (e >= 2) begin
        chk("clr_idle_ledg", {26'd0, ledg}, 32'd0);
        chk("clr_idle_ledr", {30'd0, ledr}, 32'd0);
      end
    end
    idle(3);

    // Simultaneous start and clear: clear wins, start dropped.
    op(vecs[0]);
    sw = {5'd2, 5'd3};
    key = 2'b00;
    for (int e = 0; e <= 10; e++) begin
      @(negedge clk);
      if (e == 2) key = 2'b11;
      if (e >= 2) begin
        chk("both_ledr", {30'd0, ledr}, 32'd0);
        chk("both_ledg", {26'd0, ledg}, 32'd0);
      end
    end
    idle(2);

    // Holding KEY[0] low gives exactly one operation.
    sw = {5'd6, 5'd5};
    exp_q.push_back(6'd11);
    key[0] = 1'b0;
    for (int e = 0; e <= 14; e++) begin
      @(negedge clk);
      if (e == 9) sb_check("held_key_sum");
      if (e >= 10) chk("held_key_single", {31'd0, ledr[0]}, 32'd0);
    end
    key[0] = 1'b1;
    idle(4);

    // Asynchronous reset mid-operation, then a fresh start.
    sw = {5'd9, 5'd9};
    key[0] = 1'b0;
    for (int e = 0; e <= 5; e++) begin
      @(negedge clk);
      if (e == 2) key[0] = 1'b1;
    end
    chk("pre_rst_busy", {31'd0, ledr[0]}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_ledg", {26'd0, ledg}, 32'd11 & 32'd0);
    chk("rst_ledr", {30'd0, ledr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(10);
    chk("post_rst_ledg", {26'd0, ledg}, 32'd0);
    op('{a: 5'd2, b: 5'd2, sum: 6'd4});

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
